// File: rtl/cmsdk_uart_stim_pkg.sv
// Shared types and constants for the UART stimulus transmitter.
package cmsdk_uart_stim_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cmsdk_uart_stim_fifo.sv
// Byte FIFO with occupancy count and sticky overrun flag.
module cmsdk_uart_stim_fifo
  import cmsdk_uart_stim_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LEVEL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [LEVEL_W-1:0]     level,
  output logic                   overrun
);

  localparam int AW = clog2(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic push;
  logic pop;

  // full is taken before any pop, so a write while full is lost
  assign full = (level == LEVEL_W'(DEPTH));
  assign empty = (level == '0);
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overrun <= 1'b1;
      if (push && !pop) level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cmsdk_uart_stimulus.sv
// Bench-side 8N1 UART transmitter fed from a byte FIFO.
module cmsdk_uart_stimulus
  import cmsdk_uart_stim_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LEVEL_W = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic               WR_EN,
  input  logic [7:0]         WR_DATA,
  output logic               FULL,
  output logic               EMPTY,
  output logic [LEVEL_W-1:0] LEVEL,
  output logic               OVERRUN,
  output logic               TXD,
  output logic               BUSY,
  output logic               BYTE_DONE
);

  localparam int BAUD_W = 16;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_t state;
  state_t state_next;
  logic [BAUD_W-1:0] baud;
  logic [2:0] bit_cnt;
  logic [UART_DATA_W-1:0] shreg;
  logic [UART_DATA_W-1:0] head;
  logic bit_end;
  logic pop;
  logic txd_q;

  cmsdk_uart_stim_fifo #(
    .DEPTH(FIFO_DEPTH),
    .LEVEL_W(LEVEL_W)
  ) u_fifo (
    .clk(CLK),
    .rst(RESET),
    .wr_en(WR_EN),
    .wr_data(WR_DATA),
    .rd_en(pop),
    .rd_data(head),
    .full(FULL),
    .empty(EMPTY),
    .level(LEVEL),
    .overrun(OVERRUN)
  );

  assign bit_end = (baud == BAUD_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop = 1'b0;
    unique case (state)
      IDLE: begin
        if (ENABLE && !EMPTY) begin
          state_next = START;
          pop = 1'b1;
        end
      end
      START: if (bit_end) state_next = DATA;
      DATA: if (bit_end && bit_cnt == 3'd7) state_next = STOP;
      STOP: begin
        // chain straight into the next start bit: no idle gap
        if (bit_end) begin
          if (ENABLE && !EMPTY) begin
            state_next = START;
            pop = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    TXD = txd_q;
    BUSY = (state != IDLE);
    BYTE_DONE = (state == STOP) && bit_end;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      baud <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      txd_q <= 1'b1;
    end else if (pop) begin
      baud <= '0;
      bit_cnt <= '0;
      shreg <= head;
      txd_q <= 1'b0;
    end else if (state != IDLE) begin
      baud <= bit_end ? '0 : baud + 1'b1;
      if (bit_end) begin
        unique case (state)
          START: txd_q <= shreg[0];
          DATA: begin
            if (bit_cnt == 3'd7) begin
              txd_q <= 1'b1;
            end else begin
              txd_q <= shreg[1];
              shreg <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: txd_q <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmsdk_uart_stimulus.sv
// Scoreboard bench for the UART stimulus transmitter.
module tb_cmsdk_uart_stimulus;

  localparam int CPB = 16;
  localparam int CPB2 = 2;

  logic CLK;
  logic RESET;
  logic ENABLE, WR_EN;
  logic [7:0] WR_DATA;
  logic FULL, EMPTY, OVERRUN, TXD, BUSY, BYTE_DONE;
  logic [3:0] LEVEL;
  logic m_ENABLE, m_WR_EN;
  logic [7:0] m_WR_DATA;
  logic m_FULL, m_EMPTY, m_OVERRUN, m_TXD, m_BUSY, m_BYTE_DONE;
  logic [3:0] m_LEVEL;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got, want;

  cmsdk_uart_stimulus #(
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .LEVEL_W(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL),
    .OVERRUN(OVERRUN), .TXD(TXD), .BUSY(BUSY),
    .BYTE_DONE(BYTE_DONE)
  );

  cmsdk_uart_stimulus #(
    .CLKS_PER_BIT(CPB2), .FIFO_DEPTH(8), .LEVEL_W(4)
  ) dut2 (
    .CLK(CLK), .RESET(RESET), .ENABLE(m_ENABLE),
    .WR_EN(m_WR_EN), .WR_DATA(m_WR_DATA),
    .FULL(m_FULL), .EMPTY(m_EMPTY), .LEVEL(m_LEVEL),
    .OVERRUN(m_OVERRUN), .TXD(m_TXD), .BUSY(m_BUSY),
    .BYTE_DONE(m_BYTE_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // frame bit idx: 0 start, 1..8 data LSB first, 9 stop
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // capture monitor: decodes dut TXD at mid-bit
  initial begin : monitor
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge CLK);
      if (!RESET && TXD === 1'b0) begin
        repeat (CPB / 2) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          b[i] = TXD;
        end
        repeat (CPB) @(negedge CLK);
        rx_q.push_back(b);
      end
    end
  end

  task automatic wait_rx(input int n);
    for (int i = 0; i < 4000 && rx_q.size() < n; i++) @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    ENABLE = 1'b0; WR_EN = 1'b0; WR_DATA = '0;
    m_ENABLE = 1'b0; m_WR_EN = 1'b0; m_WR_DATA = '0;
    repeat (2) @(negedge CLK);
    vectors++;
    if ({TXD, BUSY, BYTE_DONE, OVERRUN, FULL, EMPTY, LEVEL}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL reset: got %b required 1000010000",
               {TXD, BUSY, BYTE_DONE, OVERRUN, FULL, EMPTY, LEVEL});
    end
    vectors++;
    if ({m_TXD, m_BUSY, m_BYTE_DONE, m_OVERRUN, m_FULL, m_EMPTY, m_LEVEL}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL reset2: got %b required 1000010000",
               {m_TXD, m_BUSY, m_BYTE_DONE, m_OVERRUN, m_FULL, m_EMPTY, m_LEVEL});
    end
    RESET = 1'b0;
  endtask

  task automatic test_single_byte();
    int bad, first, bd_bad;
    ENABLE = 1'b1;
    WR_DATA = 8'h55; WR_EN = 1'b1;
    exp_q.push_back(8'h55);
    @(negedge CLK);
    WR_EN = 1'b0;
    vectors++;
    if ({LEVEL, TXD} !== {4'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL single_latency: level/txd %h/%b required 1/1", LEVEL, TXD);
    end
    bad = 0; first = -1; bd_bad = 0;
    for (int n = 0; n < 10 * CPB; n++) begin
      @(negedge CLK);
      if (n == 0) begin
        vectors++;
        if ({BUSY, LEVEL} !== {1'b1, 4'd0}) begin
          miscompares++;
          $display("FAIL single_start: busy/level %b/%h required 1/0", BUSY, LEVEL);
        end
      end
      if (TXD !== frame_bit(8'h55, n / CPB)) begin
        bad++;
        if (first < 0) first = n;
      end
      if (BYTE_DONE !== (n == 10 * CPB - 1)) bd_bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL single_bits: %0d bad cycles (first %0d) required 0", bad, first);
    end
    vectors++;
    if (bd_bad !== 0) begin
      miscompares++;
      $display("FAIL single_done: %0d bad cycles required 0", bd_bad);
    end
    @(negedge CLK);
    vectors++;
    if ({BUSY, TXD, BYTE_DONE} !== 3'b010) begin
      miscompares++;
      $display("FAIL single_end: busy/txd/done %b required 010", {BUSY, TXD, BYTE_DONE});
    end
    wait_rx(1);
    vectors++;
    if (rx_q.size() == 0 || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL single_rx: got no byte required 55");
    end else begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin
        miscompares++;
        $display("FAIL single_rx: got %h required %h", got, want);
      end
    end
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [3];
    int bad, first, bd_bad;
    msg = '{8'h41, 8'h42, 8'h43};
    ENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      WR_DATA = msg[i]; WR_EN = 1'b1;
      exp_q.push_back(msg[i]);
      @(negedge CLK);
      vectors++;
      if (LEVEL !== 4'(i + 1)) begin
        miscompares++;
        $display("FAIL b2b_level[%0d]: got %0d required %0d", i, LEVEL, i + 1);
      end
    end
    WR_EN = 1'b0; ENABLE = 1'b1;
    bad = 0; first = -1; bd_bad = 0;
    for (int n = 0; n < 30 * CPB; n++) begin
      @(negedge CLK);
      if (n == 0) begin
        vectors++;
        if (LEVEL !== 4'd2) begin
          miscompares++;
          $display("FAIL b2b_pop: level %0d required 2", LEVEL);
        end
      end
      if (TXD !== frame_bit(msg[n / (10 * CPB)], (n % (10 * CPB)) / CPB)) begin
        bad++;
        if (first < 0) first = n;
      end
      if (BYTE_DONE !== ((n % (10 * CPB)) == 10 * CPB - 1)) bd_bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL b2b_bits: %0d bad cycles (first %0d) required 0", bad, first);
    end
    vectors++;
    if (bd_bad !== 0) begin
      miscompares++;
      $display("FAIL b2b_done: %0d bad cycles required 0", bd_bad);
    end
    @(negedge CLK);
    vectors++;
    if ({BUSY, EMPTY} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_end: busy/empty %b required 01", {BUSY, EMPTY});
    end
    wait_rx(3);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rx_q.size() == 0 || exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL b2b_rx[%0d]: got no byte required one", i);
      end else begin
        got = rx_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin
          miscompares++;
          $display("FAIL b2b_rx[%0d]: got %h required %h", i, got, want);
        end
      end
    end
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_overrun();
    int dones;
    ENABLE = 1'b0;
    for (int i = 0; i < 9; i++) begin
      WR_DATA = 8'(8'h30 + i); WR_EN = 1'b1;
      if (i < 8) exp_q.push_back(8'(8'h30 + i));
      @(negedge CLK);
      if (i == 7) begin
        vectors++;
        if ({FULL, OVERRUN, LEVEL} !== {1'b1, 1'b0, 4'd8}) begin
          miscompares++;
          $display("FAIL ovr_full: full/ovr/level %b/%b/%0d required 1/0/8", FULL, OVERRUN, LEVEL);
        end
      end
      if (i == 8) begin
        vectors++;
        if ({FULL, OVERRUN, LEVEL} !== {1'b1, 1'b1, 4'd8}) begin
          miscompares++;
          $display("FAIL ovr_drop: full/ovr/level %b/%b/%0d required 1/1/8", FULL, OVERRUN, LEVEL);
        end
      end
    end
    WR_EN = 1'b0; ENABLE = 1'b1;
    dones = 0;
    for (int n = 0; n < 80 * CPB + 200; n++) begin
      @(negedge CLK);
      if (BYTE_DONE === 1'b1) dones++;
    end
    vectors++;
    if (dones !== 8) begin
      miscompares++;
      $display("FAIL ovr_frames: got %0d frames required 8", dones);
    end
    vectors++;
    if ({OVERRUN, EMPTY, BUSY} !== 3'b110) begin
      miscompares++;
      $display("FAIL ovr_sticky: ovr/empty/busy %b required 110", {OVERRUN, EMPTY, BUSY});
    end
    wait_rx(8);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (rx_q.size() == 0 || exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL ovr_rx[%0d]: got no byte required one", i);
      end else begin
        got = rx_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin
          miscompares++;
          $display("FAIL ovr_rx[%0d]: got %h required %h", i, got, want);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_enable_gating();
    int bad;
    logic found;
    ENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      WR_DATA = 8'(8'h61 + i); WR_EN = 1'b1;
      exp_q.push_back(8'(8'h61 + i));
      @(negedge CLK);
    end
    WR_EN = 1'b0; ENABLE = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({LEVEL, TXD} !== {4'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL gate_start: level/txd %0d/%b required 2/0", LEVEL, TXD);
    end
    repeat (5 * CPB) @(negedge CLK);
    ENABLE = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 12 * CPB && !found; n++) begin
      @(negedge CLK);
      found = BYTE_DONE;
    end
    vectors++;
    if (found !== 1'b1) begin
      miscompares++;
      $display("FAIL gate_done: byte_done %b required 1", found);
    end
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (TXD !== 1'b1 || LEVEL !== 4'd2 || BUSY !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL gate_hold: %0d bad cycles required 0", bad);
    end
    ENABLE = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({LEVEL, TXD} !== {4'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL gate_resume: level/txd %0d/%b required 1/0", LEVEL, TXD);
    end
    wait_rx(3);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rx_q.size() == 0 || exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL gate_rx[%0d]: got no byte required one", i);
      end else begin
        got = rx_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin
          miscompares++;
          $display("FAIL gate_rx[%0d]: got %h required %h", i, got, want);
        end
      end
    end
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_reset_mid_frame();
    int dones, highs;
    ENABLE = 1'b1;
    WR_DATA = 8'h5A; WR_EN = 1'b1;
    @(negedge CLK);
    WR_DATA = 8'hC3;
    @(negedge CLK);
    WR_EN = 1'b0;
    repeat (4 * CPB + 6) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    vectors++;
    if ({TXD, LEVEL, BUSY, BYTE_DONE} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_mid: txd/level/busy/done %b/%0d/%b/%b required 1/0/0/0",
               TXD, LEVEL, BUSY, BYTE_DONE);
    end
    dones = 0; highs = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (BYTE_DONE === 1'b1) dones++;
      if (TXD !== 1'b1) highs++;
    end
    vectors++;
    if (dones !== 0 || highs !== 0) begin
      miscompares++;
      $display("FAIL rst_quiet: %0d pulses %0d low cycles required 0/0", dones, highs);
    end
    rx_q.delete();
    exp_q.delete();
    WR_DATA = 8'h3C; WR_EN = 1'b1;
    exp_q.push_back(8'h3C);
    @(negedge CLK);
    WR_EN = 1'b0;
    wait_rx(1);
    vectors++;
    if (rx_q.size() == 0 || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL rst_rx: got no byte required 3c");
    end else begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin
        miscompares++;
        $display("FAIL rst_rx: got %h required %h", got, want);
      end
    end
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_min_divider();
    int bad, bd_bad;
    m_ENABLE = 1'b1;
    m_WR_DATA = 8'hA5; m_WR_EN = 1'b1;
    @(negedge CLK);
    m_WR_EN = 1'b0;
    bad = 0; bd_bad = 0;
    for (int n = 0; n < 10 * CPB2; n++) begin
      @(negedge CLK);
      if (m_TXD !== frame_bit(8'hA5, n / CPB2)) bad++;
      if (m_BYTE_DONE !== (n == 10 * CPB2 - 1)) bd_bad++;
    end
    vectors++;
    if (bad !== 0 || bd_bad !== 0) begin
      miscompares++;
      $display("FAIL min_frame: %0d bad bits %0d bad done required 0/0", bad, bd_bad);
    end
    @(negedge CLK);
    vectors++;
    if ({m_BUSY, m_TXD} !== 2'b01) begin
      miscompares++;
      $display("FAIL min_end: busy/txd %b required 01", {m_BUSY, m_TXD});
    end
    m_ENABLE = 1'b0;
    m_WR_EN = 1'b1; m_WR_DATA = 8'h11;
    @(negedge CLK);
    m_WR_DATA = 8'h22;
    @(negedge CLK);
    m_ENABLE = 1'b1; m_WR_DATA = 8'h33;
    @(negedge CLK);
    m_WR_EN = 1'b0;
    vectors++;
    if ({m_LEVEL, m_TXD} !== {4'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL min_wrpop: level/txd %0d/%b required 2/0", m_LEVEL, m_TXD);
    end
    repeat (30 * CPB2 + 10) @(negedge CLK);
    vectors++;
    if ({m_LEVEL, m_BUSY, m_TXD} !== {4'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL min_drain: level/busy/txd %0d/%b/%b required 0/0/1", m_LEVEL, m_BUSY, m_TXD);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_enable_gating();
    test_reset_mid_frame();
    test_min_divider();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
